// File: rtl/intr_ctrl_if.sv
// Bundle of the interrupt lines, mask port and control-unit handshake for intr_ctrl.
// The master side is the control unit and interrupt sources; the slave side is the controller.
interface intr_ctrl_if #(
  parameter int NSRC = 8,
  parameter int AW   = 10
);
  logic [NSRC-1:0] irq;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic            instr_boundary;
  logic            reti;
  logic            take;
  logic [AW-1:0]   vector;
  logic            in_service;
  logic [2:0]      active_id;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;

  modport master (
    output irq, mask_we, mask_wdata, instr_boundary, reti,
    input  take, vector, in_service, active_id, pending, mask
  );

  modport slave (
    input  irq, mask_we, mask_wdata, instr_boundary, reti,
    output take, vector, in_service, active_id, pending, mask
  );
endinterface

// File: rtl/intr_ctrl.sv
// Vectored, non-nesting interrupt controller: edge-detected pending latches, software mask,
// fixed priority (index 0 highest) and a redirect request issued only at instruction boundaries.
module intr_ctrl #(
  parameter int            NSRC       = 8,
  parameter int            AW         = 10,
  parameter logic [AW-1:0] VEC_BASE   = 10'h3C0,
  parameter int            VEC_STRIDE = 4
) (
  input  logic      clk,
  input  logic      reset,
  intr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_r;
  logic [NSRC-1:0] irq_prev_r;
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] mask_r;
  logic            in_service_r;
  logic [2:0]      active_id_r;

  logic [NSRC-1:0] edge_s;
  logic [NSRC-1:0] req_s;
  logic            req_any_s;
  logic [2:0]      sel_s;
  logic            take_s;
  logic [NSRC-1:0] clr_s;
  logic [NSRC-1:0] pending_nxt_s;
  logic [AW-1:0]   vector_s;

  // Lowest set index wins; scanning from the top lets lower indices overwrite.
  function automatic logic [2:0] prio_sel(input logic [NSRC-1:0] r);
    logic [2:0] s;
    s = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (r[i]) begin
        s = 3'(i);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // Vector table address, wrapping naturally at AW bits.
  function automatic logic [AW-1:0] vec_addr(input logic [2:0] s);
    return VEC_BASE + (AW'(s) * AW'(VEC_STRIDE));
  endfunction

  // Edge detection, eligibility, priority selection and the redirect decision.
  always_comb begin
    edge_s    = bus.irq & ~irq_prev_r;
    req_s     = pending_r & mask_r;
    req_any_s = |req_s;
    sel_s     = prio_sel(req_s);
    vector_s  = vec_addr(sel_s);
    if ((state_r == ARMED) && req_any_s && bus.instr_boundary) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    if (take_s) begin
      clr_s = NSRC'(1'b1) << sel_s;
    end else begin
      clr_s = {NSRC{1'b0}};
    end
    // A fresh edge on the source being taken re-pends it.
    pending_nxt_s = (pending_r & ~clr_s) | edge_s;
  end

  // Edge-detect history, pending latches and mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_r <= bus.irq;
      pending_r  <= {NSRC{1'b0}};
      mask_r     <= {NSRC{1'b0}};
    end else begin
      irq_prev_r <= bus.irq;
      pending_r  <= pending_nxt_s;
      if (bus.mask_we) begin
        mask_r <= bus.mask_wdata;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Sequencing FSM with registered in-service flag and active source id.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      in_service_r <= 1'b0;
      active_id_r  <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            state_r <= ARMED;
          end else begin
            state_r <= IDLE;
          end
        end
        ARMED: begin
          if (!req_any_s) begin
            state_r <= IDLE;
          end else if (bus.instr_boundary) begin
            state_r      <= SERVICE;
            in_service_r <= 1'b1;
            active_id_r  <= sel_s;
          end else begin
            state_r <= ARMED;
          end
        end
        SERVICE: begin
          if (bus.reti) begin
            state_r      <= IDLE;
            in_service_r <= 1'b0;
          end else begin
            state_r <= SERVICE;
          end
        end
        default: begin
          state_r      <= IDLE;
          in_service_r <= 1'b0;
          active_id_r  <= 3'd0;
        end
      endcase
    end
  end

  assign bus.take       = take_s;
  assign bus.vector     = vector_s;
  assign bus.in_service = in_service_r;
  assign bus.active_id  = active_id_r;
  assign bus.pending    = pending_r;
  assign bus.mask       = mask_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: inputs change just after each falling edge, outputs are
// sampled 1 ns later, and the rising edge in between commits the cycle.
module tb_intr_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  intr_ctrl_if #(.NSRC(8), .AW(10)) bus ();

  intr_ctrl #(.NSRC(8), .AW(10), .VEC_BASE(10'h3C0), .VEC_STRIDE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] irq_v);
    next_cycle();
    reset = 1'b1;
    bus.irq = irq_v;
    bus.mask_we = 1'b0;
    bus.mask_wdata = 8'h00;
    bus.instr_boundary = 1'b0;
    bus.reti = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL reset_take: got %b want 0", bus.take); end
    checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL reset_in_service: got %b want 0", bus.in_service); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", bus.pending); end
    checks++; if (bus.mask !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h want 00", bus.mask); end
    checks++; if (bus.active_id !== 3'd0) begin errors++; $display("FAIL reset_active_id: got %0d want 0", bus.active_id); end
  endtask

  task automatic test_basic();
    do_reset(8'h00);
    next_cycle(); bus.mask_we = 1'b1; bus.mask_wdata = 8'h01; bus.instr_boundary = 1'b1;
    next_cycle(); bus.mask_we = 1'b0; bus.irq = 8'h01; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL basic_edge_cycle_take: got %b want 0", bus.take); end
    next_cycle(); bus.irq = 8'h00; #1;
    checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL basic_pending: got %h want 01", bus.pending); end
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL basic_n1_take: got %b want 0", bus.take); end
    next_cycle(); #1;
    checks++; if (bus.take !== 1'b1) begin errors++; $display("FAIL basic_take: got %b want 1", bus.take); end
    checks++; if (bus.vector !== 10'h3C0) begin errors++; $display("FAIL basic_vector: got %h want 3c0", bus.vector); end
    next_cycle(); #1;
    checks++; if (bus.in_service !== 1'b1) begin errors++; $display("FAIL basic_in_service: got %b want 1", bus.in_service); end
    checks++; if (bus.active_id !== 3'd0) begin errors++; $display("FAIL basic_active_id: got %0d want 0", bus.active_id); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL basic_pending_cleared: got %h want 00", bus.pending); end
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL basic_no_double_take: got %b want 0", bus.take); end
    next_cycle(); bus.reti = 1'b1; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL basic_reti_cycle_take: got %b want 0", bus.take); end
    next_cycle(); bus.reti = 1'b0; #1;
    checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL basic_after_reti: got %b want 0", bus.in_service); end
  endtask

  task automatic test_priority();
    do_reset(8'h00);
    next_cycle(); bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF;
    next_cycle(); bus.mask_we = 1'b0; bus.irq = 8'h20;
    next_cycle();
    next_cycle(); bus.irq = 8'h24; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL prio_no_boundary_take: got %b want 0", bus.take); end
    next_cycle(); bus.instr_boundary = 1'b1; #1;
    checks++; if (bus.pending !== 8'h24) begin errors++; $display("FAIL prio_pending_both: got %h want 24", bus.pending); end
    checks++; if (bus.take !== 1'b1) begin errors++; $display("FAIL prio_take: got %b want 1", bus.take); end
    checks++; if (bus.vector !== 10'h3C8) begin errors++; $display("FAIL prio_vector_src2: got %h want 3c8", bus.vector); end
    next_cycle(); bus.instr_boundary = 1'b0; #1;
    checks++; if (bus.pending !== 8'h20) begin errors++; $display("FAIL prio_pending_remain: got %h want 20", bus.pending); end
    checks++; if (bus.active_id !== 3'd2) begin errors++; $display("FAIL prio_active_id: got %0d want 2", bus.active_id); end
    next_cycle(); bus.reti = 1'b1;
    next_cycle(); bus.reti = 1'b0; bus.instr_boundary = 1'b1; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL prio_rearm_take: got %b want 0", bus.take); end
    next_cycle(); #1;
    checks++; if (bus.take !== 1'b1) begin errors++; $display("FAIL prio_take_src5: got %b want 1", bus.take); end
    checks++; if (bus.vector !== 10'h3D4) begin errors++; $display("FAIL prio_vector_src5: got %h want 3d4", bus.vector); end
    next_cycle(); bus.instr_boundary = 1'b0; bus.irq = 8'h00; #1;
    checks++; if (bus.active_id !== 3'd5) begin errors++; $display("FAIL prio_active_id5: got %0d want 5", bus.active_id); end
  endtask

  task automatic test_masking();
    do_reset(8'h00);
    next_cycle(); bus.mask_we = 1'b1; bus.mask_wdata = 8'h00; bus.instr_boundary = 1'b1;
    next_cycle(); bus.mask_we = 1'b0; bus.irq = 8'h08;
    next_cycle(); bus.irq = 8'h00; #1;
    checks++; if (bus.pending !== 8'h08) begin errors++; $display("FAIL mask_pending: got %h want 08", bus.pending); end
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL mask_masked_take: got %b want 0", bus.take); end
    next_cycle(); bus.mask_we = 1'b1; bus.mask_wdata = 8'h08; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL mask_write_cycle_take: got %b want 0", bus.take); end
    next_cycle(); bus.mask_we = 1'b0; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL mask_arming_take: got %b want 0", bus.take); end
    next_cycle(); #1;
    checks++; if (bus.take !== 1'b1) begin errors++; $display("FAIL mask_unmasked_take: got %b want 1", bus.take); end
    checks++; if (bus.vector !== 10'h3CC) begin errors++; $display("FAIL mask_vector: got %h want 3cc", bus.vector); end
    next_cycle(); bus.instr_boundary = 1'b0; bus.reti = 1'b1;
    next_cycle(); bus.reti = 1'b0; bus.mask_we = 1'b1; bus.mask_wdata = 8'h00; bus.irq = 8'h08;
    next_cycle(); bus.mask_wdata = 8'h08; bus.irq = 8'h00;
    next_cycle(); bus.mask_wdata = 8'h00;
    next_cycle(); bus.mask_we = 1'b0; bus.instr_boundary = 1'b1; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL mask_remask_take: got %b want 0", bus.take); end
    next_cycle(); #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL mask_idle_take: got %b want 0", bus.take); end
    checks++; if (bus.pending !== 8'h08) begin errors++; $display("FAIL mask_still_pending: got %h want 08", bus.pending); end
    checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL mask_not_in_service: got %b want 0", bus.in_service); end
  endtask

  task automatic test_no_nesting();
    do_reset(8'h00);
    next_cycle(); bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF; bus.instr_boundary = 1'b1;
    next_cycle(); bus.mask_we = 1'b0; bus.irq = 8'h02;
    next_cycle(); bus.irq = 8'h00;
    next_cycle(); #1;
    checks++; if (bus.vector !== 10'h3C4 || bus.take !== 1'b1) begin errors++; $display("FAIL nest_first_take: got take=%b vector=%h want 1/3c4", bus.take, bus.vector); end
    next_cycle(); bus.irq = 8'h01; #1;
    checks++; if (bus.active_id !== 3'd1) begin errors++; $display("FAIL nest_active_id: got %0d want 1", bus.active_id); end
    next_cycle(); bus.irq = 8'h00; #1;
    checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL nest_pending0: got %h want 01", bus.pending); end
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL nest_held_take: got %b want 0", bus.take); end
    next_cycle(); bus.reti = 1'b1; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL nest_reti_boundary_take: got %b want 0", bus.take); end
    next_cycle(); bus.reti = 1'b0; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL nest_rearm_take: got %b want 0", bus.take); end
    next_cycle(); #1;
    checks++; if (bus.take !== 1'b1 || bus.vector !== 10'h3C0) begin errors++; $display("FAIL nest_src0_take: got take=%b vector=%h want 1/3c0", bus.take, bus.vector); end
    next_cycle(); bus.instr_boundary = 1'b0; #1;
    checks++; if (bus.in_service !== 1'b1 || bus.active_id !== 3'd0) begin errors++; $display("FAIL nest_src0_service: got in_service=%b id=%0d want 1/0", bus.in_service, bus.active_id); end
  endtask

  task automatic test_set_clear();
    do_reset(8'h00);
    next_cycle(); bus.mask_we = 1'b1; bus.mask_wdata = 8'h10;
    next_cycle(); bus.mask_we = 1'b0; bus.irq = 8'h10;
    next_cycle(); bus.irq = 8'h00;
    next_cycle();
    next_cycle(); bus.instr_boundary = 1'b1; bus.irq = 8'h10; #1;
    checks++; if (bus.take !== 1'b1 || bus.vector !== 10'h3D0) begin errors++; $display("FAIL setclr_take: got take=%b vector=%h want 1/3d0", bus.take, bus.vector); end
    next_cycle(); bus.instr_boundary = 1'b0; #1;
    checks++; if (bus.pending !== 8'h10) begin errors++; $display("FAIL setclr_repend: got %h want 10", bus.pending); end
    checks++; if (bus.in_service !== 1'b1) begin errors++; $display("FAIL setclr_in_service: got %b want 1", bus.in_service); end
  endtask

  task automatic test_reset_behaviour();
    do_reset(8'hFF);
    next_cycle(); bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF; bus.instr_boundary = 1'b1;
    next_cycle(); bus.mask_we = 1'b0; #1;
    checks++; if (bus.take !== 1'b0) begin errors++; $display("FAIL rst_high_take1: got %b want 0", bus.take); end
    next_cycle(); #1;
    checks++; if (bus.take !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("FAIL rst_high_no_edge: got take=%b pending=%h want 0/00", bus.take, bus.pending); end
    next_cycle(); bus.irq = 8'h00;
    next_cycle(); bus.irq = 8'h01;
    next_cycle();
    next_cycle(); #1;
    checks++; if (bus.take !== 1'b1) begin errors++; $display("FAIL rst_pre_take: got %b want 1", bus.take); end
    next_cycle(); bus.irq = 8'h03; reset = 1'b1; #1;
    checks++; if (bus.in_service !== 1'b1) begin errors++; $display("FAIL rst_pre_service: got %b want 1", bus.in_service); end
    next_cycle(); reset = 1'b0; #1;
    checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL rst_abort_in_service: got %b want 0", bus.in_service); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_abort_pending: got %h want 00", bus.pending); end
    checks++; if (bus.mask !== 8'h00 || bus.take !== 1'b0) begin errors++; $display("FAIL rst_abort_mask_take: got mask=%h take=%b want 00/0", bus.mask, bus.take); end
    next_cycle(); #1;
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_no_edge_after: got %h want 00", bus.pending); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.irq = 8'h00;
    bus.mask_we = 1'b0;
    bus.mask_wdata = 8'h00;
    bus.instr_boundary = 1'b0;
    bus.reti = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_masking();
    test_no_nesting();
    test_set_clear();
    test_reset_behaviour();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller that sequences vectored interrupts into the single-cycle CPU datapath.
- Detects rising edges on external interrupt lines, latches them as pending, and applies a software mask.
- Selects the highest-priority unmasked source and tells the control unit when to redirect the PC at an instruction boundary.
- Supplies the 10-bit vector address the datapath's PC mux selects, tracks in-service state until return-from-interrupt, and allows no nesting.

Parameters:
NSRC, 8, number of interrupt sources (index 0 = highest priority)
AW, 10, program address width (matches PC width)
VEC_BASE, 10'h3C0, address of vector for source 0
VEC_STRIDE, 4, address distance between consecutive vectors

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
irq  input  NSRC  external interrupt lines, edge-sensitive (rising)
mask_we  input  1  write enable for mask register
mask_wdata  input  NSRC  new mask value (1 = source enabled)
instr_boundary  input  1  from control unit: current cycle completes an instruction, redirect allowed
reti  input  1  from control unit: return-from-interrupt executing this cycle
take  output  1  redirect now: control unit drives s_inc=2, push=1, s_intr=1 this cycle
vector  output  AW  target PC for the interrupt being taken (valid when take=1)
in_service  output  1  handler running
active_id  output  3  index of source in service (valid when in_service=1)
pending  output  NSRC  latched pending bits
mask  output  NSRC  current mask register

Behaviour:
- Reset:
  - pending=0, mask=0, state=IDLE, in_service=0, active_id=0, take=0.
  - The edge-detect register loads the current irq during reset, so a line already high at reset release is not an edge.
- Edge detect: irq_prev <= irq each cycle. edge[i] = irq[i] & ~irq_prev[i].
- Pending update, per bit each cycle:
  - Set by edge[i].
  - Cleared when source i is taken.
  - Set and clear in the same cycle: set wins, so the source re-pends.
  - Pending bits accumulate regardless of mask or state.
- Mask: mask <= mask_wdata when mask_we. A take in the same cycle uses the old mask.
- Eligibility:
  - req = pending & mask.
  - sel = lowest set index of req (fixed priority).
  - vector = VEC_BASE + sel*VEC_STRIDE, computed combinationally in AW bits; overflow wraps modulo 2^AW.
- FSM states IDLE, ARMED, SERVICE:
  - IDLE: if req!=0 -> ARMED next cycle.
  - ARMED:
    - If req==0 (masked away or cleared): -> IDLE, no take.
    - Else if instr_boundary: take=1 combinationally this cycle with vector from the current sel. Latch active_id<=sel, clear pending[sel], -> SERVICE.
    - Else stay ARMED; sel is re-evaluated every cycle, so a higher-priority arrival overtakes.
  - SERVICE: in_service=1. New edges still pend, but take is held 0. On reti -> IDLE; the next cycle re-arms if req!=0.
- take is asserted only in ARMED with instr_boundary=1 and req!=0. It is never asserted for two consecutive cycles.
- reti outside SERVICE is ignored. reti and instr_boundary in the same SERVICE cycle: reti handled, no take that cycle.
- Minimum latency from an irq edge at cycle N to take: cycle N+2, when instr_boundary=1 and the source is unmasked. The edge is registered at N+1 (IDLE->ARMED) and the take fires at N+2.
- Reset during SERVICE or ARMED aborts immediately to the reset values; the control unit owns stack cleanup.

Test Plan:
- Basic take: mask=8'h01; pulse irq[0] at cycle 10; instr_boundary=1 constantly -> take=1 at cycle 12 with vector=10'h3C0; active_id=0; in_service=1 from 13; pending[0]=0.
- Priority and overtake: mask=8'hFF, instr_boundary=0; edge on irq[5], then irq[2] two cycles later; raise instr_boundary -> vector=10'h3C8 (source 2); pending=8'h20 remains; after reti, source 5 is taken with vector=10'h3D4.
- Masking: mask=0, edge on irq[3] -> no take, pending=8'h08. Write mask=8'h08 -> take two cycles later with vector=10'h3CC. Unmasking then re-masking before instr_boundary -> FSM returns to IDLE, no take.
- No nesting: while in SERVICE on source 1, edge on irq[0] -> take stays 0, pending[0]=1; reti -> take for source 0 at the first boundary after re-arming.
- Simultaneous set/clear: edge on irq[4] in the same cycle source 4 is taken -> pending[4]=1 afterwards.
- Reset: irq=8'hFF held high through reset, mask=8'hFF afterwards -> no take (no edges). Assert reset during SERVICE -> in_service=0 and pending=0 the next cycle.
